key_conditioner: RTL

//  Conditions one raw push-button for the FSMs on the board: 2-flop synchronizer,

---
 rtl/key_conditioner.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/key_conditioner.sv
// Push-button conditioner: synchronizer, debouncer, press/release pulses.
// Optional hold auto-repeat when KEY_CONDITIONER_AUTOREPEAT_EN is defined.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int MAX_DR = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                            DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAXV   = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int CW     = $clog2(MAXV + 1);
    localparam logic [CW-1:0] D_M1 = CW'(DEBOUNCE_CYCLES - 1);
    localparam bit D_ONE  = (DEBOUNCE_CYCLES == 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          norm;
    logic          sync1;
    logic          s;

    assign norm = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= norm;
            s     <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RELEASED;
            cnt           <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            unique case (state)
                RELEASED: begin
                    if (s && D_ONE) begin
                        state <= HELD;
                        level <= 1'b1;
                        press <= 1'b1;
                    end else if (s) begin
                        state <= PRESS_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == D_M1) begin
                        state <= HELD;
                        cnt   <= '0;
                        level <= 1'b1;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HELD: begin
                    if (!s && D_ONE) begin
                        state         <= RELEASED;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                    end else if (!s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == D_M1) begin
                        state         <= RELEASED;
                        cnt           <= '0;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
    logic [CW-1:0] htmr;
    logic          first_rep;
    logic [CW-1:0] tgt;

    assign tgt = first_rep ? CW'(REPEAT_DELAY) : CW'(REPEAT_PERIOD);

    // Timer only advances on cycles that stay in HELD; any other cycle rearms it.
    always_ff @(posedge clk) begin
        if (reset) begin
            htmr         <= '0;
            first_rep    <= 1'b1;
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= 1'b0;
            if (state == HELD && s) begin
                if (htmr + CW'(1) == tgt) begin
                    htmr         <= '0;
                    first_rep    <= 1'b0;
                    repeat_pulse <= 1'b1;
                end else begin
                    htmr <= htmr + CW'(1);
                end
            end else begin
                htmr      <= '0;
                first_rep <= 1'b1;
            end
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule
